pwm_ramp_sequencer: RTL

- Ramps one PWM channel's high-time register (16-bit PWMH, split across two byte registers) from its current value to a target, one step per programmable interval.
- Sits between the host register-write path and the byte-wide register file that feeds the PWM generators.
- Arbitrates the single register write port between host writes and its own writes.
- The two bytes of each 16-bit sequencer update are written as an atomic pair.

---
 rtl/pwm_ramp_sequencer.sv | 103 ++++++++++
 1 files changed

// File: rtl/pwm_ramp_sequencer.sv
// pwm_ramp_sequencer: steps a 16-bit PWM duty register toward a target, sharing the byte write port with the host.
// Optional PWM_SEQ_SNOOP_EN: host writes to the duty bytes also update cur_duty.
module pwm_ramp_sequencer #(
    parameter int                ADDR_W  = 5,
    parameter logic [ADDR_W-1:0] LO_ADDR = 5'h4,
    parameter logic [ADDR_W-1:0] HI_ADDR = 5'h5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [15:0]       i_target,
    input  logic [15:0]       i_step,
    input  logic [15:0]       i_interval,
    output logic              o_busy,
    output logic              o_done,
    output logic [15:0]       o_cur_duty,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [7:0]        i_host_wdata,
    output logic              o_host_ack,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data
);
    typedef enum logic [1:0] {IDLE, WAIT, WR_LO, WR_HI} state_t;

    state_t      r_state, w_next_state;
    logic [15:0] r_target, r_step, r_interval, r_cnt, r_cur;
    logic        r_done;
    logic [16:0] w_sum, w_diff;
    logic [15:0] w_next_d, w_ivl, w_cur_nxt;
    logic        w_start_ok, w_start_nop, w_seq_lo, w_seq_hi;

    // 17-bit arithmetic so the step saturates at the target instead of wrapping
    assign w_sum    = {1'b0, r_cur} + {1'b0, r_step};
    assign w_diff   = {1'b0, r_cur} - {1'b0, r_step};
    assign w_next_d = (r_cur < r_target) ? ((w_sum > {1'b0, r_target}) ? r_target : w_sum[15:0])
                    : (r_cur > r_target) ? ((w_diff[16] || w_diff[15:0] < r_target) ? r_target : w_diff[15:0])
                    : r_target;

    assign w_ivl       = (i_interval == 16'd0) ? 16'd1 : i_interval;
    assign w_start_ok  = (r_state == IDLE) && i_start && !i_abort;
    assign w_start_nop = w_start_ok && (i_step == 16'd0 || i_target == r_cur);

    assign w_seq_lo   = (r_state == WR_LO) && !i_host_we && !i_abort;
    assign w_seq_hi   = (r_state == WR_HI);
    assign o_host_ack = i_rst_n && i_host_we && !w_seq_hi;
    assign o_wr_en    = o_host_ack || (i_rst_n && (w_seq_lo || w_seq_hi));
    assign o_wr_addr  = w_seq_hi ? HI_ADDR : w_seq_lo ? LO_ADDR : i_host_addr;
    assign o_wr_data  = w_seq_hi ? w_next_d[15:8] : w_seq_lo ? w_next_d[7:0] : i_host_wdata;

    assign o_busy     = (r_state != IDLE);
    assign o_done     = r_done;
    assign o_cur_duty = r_cur;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:  w_next_state = (w_start_ok && !w_start_nop) ? WAIT : IDLE;
            WAIT:  w_next_state = i_abort ? IDLE : (r_cnt <= 16'd1) ? WR_LO : WAIT;
            WR_LO: w_next_state = i_abort ? IDLE : i_host_we ? WR_LO : WR_HI;
            WR_HI: w_next_state = (i_abort || w_next_d == r_target) ? IDLE : WAIT;
        endcase
    end

    always_comb begin
        w_cur_nxt = w_seq_hi ? w_next_d : r_cur;
`ifdef PWM_SEQ_SNOOP_EN
        if (o_host_ack && i_host_addr == LO_ADDR) w_cur_nxt[7:0] = i_host_wdata;
        if (o_host_ack && i_host_addr == HI_ADDR) w_cur_nxt[15:8] = i_host_wdata;
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_target   <= 16'd0;
            r_step     <= 16'd0;
            r_interval <= 16'd0;
            r_cnt      <= 16'd0;
            r_cur      <= 16'd0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_start_nop || (w_seq_hi && !i_abort && w_next_d == r_target);
            r_cur  <= w_cur_nxt;
            if (w_start_ok) begin
                r_target   <= i_target;
                r_step     <= i_step;
                r_interval <= w_ivl;
                r_cnt      <= w_ivl;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 16'd1;
            end else if (w_seq_hi) begin
                r_cnt <= r_interval;
            end
        end
    end
endmodule
